// File: rtl/lcd_if.sv
// lcd_if -- signal bundle between the HD44780 driver and its neighbours.
//   char_in    : ASCII byte for the requested position (from the content stage)
//   index      : character position requested (0-15 line 1, 16-31 line 2)
//   lcd_data   : 8-bit HD44780 data bus
//   lcd_rs     : 0 = command, 1 = character data
//   lcd_rw     : always 0 (write only)
//   lcd_e      : enable strobe
//   init_done  : init sequence complete, held until reset
//   frame_done : one-cycle pulse when the refresh wraps from index 31 to 0
// master = driver side, slave = content stage / panel side.
interface lcd_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  char_in,
        output index, lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
    );

    modport slave (
        output char_in,
        input  index, lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
    );
endinterface

// File: rtl/lcd_driver.sv
// lcd_driver -- HD44780 8-bit write-only driver with continuous 2x16 refresh.
//   clk : single clock, posedge
//   rst : asynchronous active-high reset
//   bus : lcd_if.master (char_in in; index, lcd_* strobes, init_done, frame_done out)
// After POWERUP_WAIT idle cycles the four init commands are sent, then the
// display is refreshed forever: address 0x80, chars 0-15, address 0xC0,
// chars 16-31. Every bus write is SETUP (1 cycle) -> E_HIGH (E_PULSE) ->
// E_WAIT (STEP_CYCLES, or CLR_CYCLES after the clear command).
module lcd_driver #(
    parameter int POWERUP_WAIT = 750000,
    parameter int E_PULSE      = 25,
    parameter int STEP_CYCLES  = 2500,
    parameter int CLR_CYCLES   = 100000
) (
    input  logic  clk,
    input  logic  rst,
    lcd_if.master bus
);
    // Counter is never narrower than 20 bits and grows with the largest wait.
    localparam int MAX_A = (POWERUP_WAIT > CLR_CYCLES) ? POWERUP_WAIT : CLR_CYCLES;
    localparam int MAX_B = (STEP_CYCLES > E_PULSE) ? STEP_CYCLES : E_PULSE;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = ($clog2(MAX_C + 1) > 20) ? $clog2(MAX_C + 1) : 20;

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_WAIT - 1);
    localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_PULSE - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);

    // state_q walks PWR_WAIT, FETCH and the shared SETUP/E_HIGH/E_WAIT
    // sub-sequence. phase_q records which command class (INIT_CMD, SET_ADDR,
    // WRITE_CHAR) the in-flight transaction belongs to, so the decision of
    // what comes next is taken in the last wait cycle with no dead cycle.
    typedef enum logic [2:0] {
        PWR_WAIT, INIT_CMD, SET_ADDR, FETCH, WRITE_CHAR, SETUP, E_HIGH, E_WAIT
    } state_t;

    state_t           state_q, state_d;
    state_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic [4:0]       index_q, index_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             init_done_q, init_done_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] wait_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h38;  // function set: 8-bit, 2 lines, 5x8
            2'd1:    return 8'h0C;  // display on, cursor off
            2'd2:    return 8'h06;  // entry mode: increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction

    // Only the clear command needs the long wait.
    assign wait_last = (phase_q == INIT_CMD && step_q == 2'd3) ? CLR_LAST : STEP_LAST;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q + CNT_W'(1);
        step_d      = step_q;
        index_d     = index_q;
        data_d      = data_q;
        rs_d        = rs_q;
        e_d         = e_q;
        init_done_d = init_done_q;
        frame_d     = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = SETUP;
                    phase_d = INIT_CMD;
                    step_d  = 2'd0;
                    data_d  = init_cmd(2'd0);
                    rs_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            // index has been stable for two cycles, so the registered
            // char_in now belongs to it.
            FETCH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SETUP;
                    phase_d = WRITE_CHAR;
                    data_d  = bus.char_in;
                    rs_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = E_HIGH;
                e_d     = 1'b1;
                cnt_d   = '0;
            end
            E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    state_d = E_WAIT;
                    e_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            E_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    case (phase_q)
                        INIT_CMD: begin
                            state_d = SETUP;
                            rs_d    = 1'b0;
                            if (step_q == 2'd3) begin
                                init_done_d = 1'b1;
                                phase_d     = SET_ADDR;
                                data_d      = 8'h80;
                            end else begin
                                step_d = step_q + 2'd1;
                                data_d = init_cmd(step_q + 2'd1);
                            end
                        end
                        SET_ADDR: state_d = FETCH;
                        default: begin
                            index_d = index_q + 5'd1;
                            // Line boundaries go through an address command.
                            if (index_q == 5'd15 || index_q == 5'd31) begin
                                state_d = SETUP;
                                phase_d = SET_ADDR;
                                rs_d    = 1'b0;
                                data_d  = (index_q == 5'd31) ? 8'h80 : 8'hC0;
                                frame_d = (index_q == 5'd31);
                            end else begin
                                state_d = FETCH;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            phase_q     <= INIT_CMD;
            cnt_q       <= '0;
            step_q      <= 2'd0;
            index_q     <= 5'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            init_done_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            index_q     <= index_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            init_done_q <= init_done_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.index      = index_q;
    assign bus.lcd_data   = data_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_q;
endmodule

// File: doc/lcd_driver.md
LCD_DRIVER -- requirements
Module: lcd_driver

Interface
REQ-001 SHALL have parameter POWERUP_WAIT, default 750000, meaning the clk cycles idle after reset before the first command (15 ms at 50 MHz).
REQ-002 SHALL have parameter E_PULSE, default 25, meaning the clk cycles lcd_e is held high per transaction.
REQ-003 SHALL have parameter STEP_CYCLES, default 2500, meaning the idle clk cycles after each lcd_e fall for normal commands and characters.
REQ-004 SHALL have parameter CLR_CYCLES, default 100000, meaning the idle clk cycles after the clear-display command.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port char_in, input, 8 bits: ASCII character from the display-content stage for the current index, registered there one clk after index changes.
REQ-008 SHALL have port index, output, 5 bits: character position requested (0-15 line 1, 16-31 line 2).
REQ-009 SHALL have port lcd_data, output, 8 bits: HD44780 8-bit data bus.
REQ-010 SHALL have port lcd_rs, output, 1 bit: 0 = command, 1 = character data.
REQ-011 SHALL have port lcd_rw, output, 1 bit: tied to 0 (write only).
REQ-012 SHALL have port lcd_e, output, 1 bit: enable strobe.
REQ-013 SHALL have port init_done, output, 1 bit: high once the init sequence completes; stays high until reset.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the character at index 31 is written.

Function
REQ-015 SHALL implement states PWR_WAIT, INIT_CMD, SET_ADDR, FETCH, WRITE_CHAR, and a shared transaction sub-sequence SETUP -> E_HIGH -> E_WAIT.
REQ-016 SHALL make each transaction 1 SETUP cycle (lcd_rs/lcd_data driven, lcd_e=0), then E_PULSE cycles with lcd_e=1, then STEP_CYCLES (or CLR_CYCLES) cycles with lcd_e=0.
REQ-017 SHALL hold lcd_rs and lcd_data stable from SETUP until the next transaction's SETUP.
REQ-018 SHALL remain in PWR_WAIT for POWERUP_WAIT cycles after reset release, with lcd_e=0.
REQ-019 SHALL issue INIT_CMD commands in this order: 0x38 (function set), 0x0C (display on), 0x06 (entry mode), 0x01 (clear, followed by CLR_CYCLES wait); all with lcd_rs=0.
REQ-020 SHALL set init_done=1 in the cycle after the clear wait ends, then enter SET_ADDR with address 0x80.
REQ-021 SHALL issue the SET_ADDR command 0x80 when index=0 and 0xC0 when index=16 (lcd_rs=0).
REQ-022 SHALL, in FETCH, hold index constant for exactly 2 cycles, then latch char_in into lcd_data at the WRITE_CHAR SETUP cycle, with lcd_rs=1.
REQ-023 SHALL, after each WRITE_CHAR wait, increment index; index 15->16 and index 31->0 SHALL each go through SET_ADDR first, and all other values go directly to FETCH.
REQ-024 SHALL wrap index 31 to 0 (5-bit natural wrap) and pulse frame_done for 1 cycle in the same cycle index becomes 0; refresh SHALL then repeat indefinitely.
REQ-025 SHALL use wait counters at least 20 bits wide; with CLR_CYCLES up to 2^20-1, the counters SHALL NOT overflow.
REQ-026 SHALL NOT alter an in-progress transaction or the index sequence when char_in changes outside the FETCH latch cycle.

Reset
REQ-027 SHALL, while rst=1, asynchronously force: state=PWR_WAIT, counters=0, index=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, init_done=0, frame_done=0.
REQ-028 SHALL, if rst asserts mid-transaction (including with lcd_e=1), drop lcd_e immediately and restart the full power-up and init sequence after release.

Verification (POWERUP_WAIT=20, E_PULSE=2, STEP_CYCLES=5, CLR_CYCLES=10)
REQ-029 SHALL verify power-up: release rst -> lcd_e stays 0 for 20 cycles, then lcd_e pulses 2 cycles with lcd_data=0x38 and lcd_rs=0.
REQ-030 SHALL verify init: init_done rises only after 4 commands (0x38, 0x0C, 0x06, 0x01) with 5/5/5/10-cycle low gaps respectively; the next transaction is 0x80.
REQ-031 SHALL verify data path: a model returns char_in=0x30+index registered 1 cycle -> the byte written at index n is 0x30+n with lcd_rs=1, for all 32 positions.
REQ-032 SHALL verify line change: after the index-15 write, command 0xC0 precedes the index-16 write; after the index-31 write, frame_done pulses once, command 0x80 is issued, and index=0.
REQ-033 SHALL verify reset mid-pulse: assert rst while lcd_e=1 in character writing -> lcd_e=0 the same cycle; after release, the 20-cycle wait and 0x38 repeat, and init_done=0 until the new init completes.
